// File: rtl/rbz_spi_pkg.sv
// rbz_spi_pkg: shared state encoding and vector frame sizing for the raybox-zero SPI masters
package rbz_spi_pkg;
    localparam int VEC_FIELD_BITS = 15;
    localparam int VEC_COUNT      = 6;
    localparam int VEC_FRAME_BITS = VEC_COUNT * VEC_FIELD_BITS;
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SCLK_HI,
        ST_SCLK_LO,
        ST_HOLD,
        ST_GAP
    } spi_state_e;
endpackage

// File: rtl/spi_tick_gen.sv
// spi_tick_gen: CLK_DIV phase timer, tick marks the last cycle of each phase
module spi_tick_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_restart,
    output logic o_tick
);
    localparam int W = $clog2(CLK_DIV) + 1;
    localparam logic [W-1:0] RELOAD = W'(CLK_DIV - 1);
    logic [W-1:0] r_cnt;
    // reload on every phase entry, then count down and hold at zero
    always_ff @(posedge i_clk)
        if (i_reset) r_cnt <= '0;
        else r_cnt <= i_restart ? RELOAD : (r_cnt != '0 ? r_cnt - 1'b1 : r_cnt);
    assign o_tick = (r_cnt == '0);
endmodule

// File: rtl/vec_spi_master.sv
// vec_spi_master: mode-0 SPI master sending one view-vector frame, with a latest-wins pending slot
module vec_spi_master
    import rbz_spi_pkg::*;
#(
    parameter int FRAME_BITS = VEC_FRAME_BITS,
    parameter int CLK_DIV    = 2,
    parameter int GAP        = 2
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_start,
    input  logic [FRAME_BITS-1:0] i_data,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_vec_csb,
    output logic                  o_vec_sclk,
    output logic                  o_vec_mosi
);
    localparam int BW = $clog2(FRAME_BITS + 1);
    localparam int GW = $clog2(GAP) + 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(FRAME_BITS);
    localparam logic [GW-1:0] GAP_LOAD = GW'(GAP - 1);

    spi_state_e            r_state;
    logic [FRAME_BITS-1:0] r_shift;
    logic [FRAME_BITS-1:0] r_pend;
    logic                  r_pend_vld;
    logic [BW-1:0]         r_bits;
    logic [GW-1:0]         r_gap;
    logic                  r_csb;
    logic                  r_sclk;
    logic                  r_mosi;
    logic                  r_busy;
    logic                  r_done;
    logic                  w_tick;
    logic                  w_restart;
    logic                  w_gap_end;
    logic                  w_load;
    logic [FRAME_BITS-1:0] w_load_data;

    spi_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_restart(w_restart),
        .o_tick   (w_tick)
    );

    // frame load decision: a fresh start always beats the older pending value
    always_comb begin
        w_gap_end   = (r_state == ST_GAP) && (r_gap == '0);
        w_load      = (r_state == ST_IDLE) ? i_start : (w_gap_end && (i_start || r_pend_vld));
        w_load_data = i_start ? i_data : r_pend;
        w_restart   = (r_state == ST_IDLE) ? i_start : (r_state == ST_GAP) ? w_gap_end : w_tick;
    end

    // frame sequencer with registered SPI pins, busy and done
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= ST_IDLE;
            r_shift    <= '0;
            r_pend     <= '0;
            r_pend_vld <= 1'b0;
            r_bits     <= '0;
            r_gap      <= '0;
            r_csb      <= 1'b1;
            r_sclk     <= 1'b0;
            r_mosi     <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (i_start && r_state != ST_IDLE) begin
                r_pend     <= i_data;
                r_pend_vld <= 1'b1;
            end
            if (w_load) begin
                r_state <= ST_SETUP;
                r_shift <= w_load_data;
                r_mosi  <= w_load_data[FRAME_BITS-1];
                r_csb   <= 1'b0;
                r_bits  <= '0;
                r_busy  <= 1'b1;
                if (r_state == ST_GAP) r_pend_vld <= 1'b0;
            end else if (w_gap_end) begin
                r_state <= ST_IDLE;
                r_busy  <= 1'b0;
            end else if (r_state == ST_GAP) begin
                r_gap <= r_gap - 1'b1;
            end else if (w_tick) begin
                case (r_state)
                    ST_SETUP, ST_SCLK_LO: begin
                        r_state <= ST_SCLK_HI;
                        r_sclk  <= 1'b1;
                        r_bits  <= r_bits + 1'b1;
                    end
                    ST_SCLK_HI: begin
                        r_sclk <= 1'b0;
                        if (r_bits == LAST_BIT) begin
                            r_state <= ST_HOLD;
                        end else begin
                            r_state <= ST_SCLK_LO;
                            r_shift <= r_shift << 1;
                            r_mosi  <= r_shift[FRAME_BITS-2];
                        end
                    end
                    ST_HOLD: begin
                        r_state <= ST_GAP;
                        r_csb   <= 1'b1;
                        r_mosi  <= 1'b0;
                        r_done  <= 1'b1;
                        r_gap   <= GAP_LOAD;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign o_busy     = r_busy;
    assign o_done     = r_done;
    assign o_vec_csb  = r_csb;
    assign o_vec_sclk = r_sclk;
    assign o_vec_mosi = r_mosi;
endmodule

// File: tb/tb_vec_spi_master.sv
// tb_vec_spi_master: directed checks of vec_spi_master against a mode-0 slave model
module tb_vec_spi_master;
    import rbz_spi_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        a_start = 1'b0, b_start = 1'b0;
    logic [89:0] a_data = '0;
    logic [7:0]  b_data = '0;
    logic        a_busy, a_done, a_csb, a_sclk, a_mosi;
    logic        b_busy, b_done, b_csb, b_sclk, b_mosi;
    int          n_checks = 0, n_errors = 0, cyc = 0, t0 = 0;

    always @(posedge clk) cyc <= cyc + 1;

    vec_spi_master #(.FRAME_BITS(VEC_FRAME_BITS), .CLK_DIV(2), .GAP(2)) u_dut_a (
        .i_clk(clk), .i_reset(rst), .i_start(a_start), .i_data(a_data),
        .o_busy(a_busy), .o_done(a_done), .o_vec_csb(a_csb), .o_vec_sclk(a_sclk), .o_vec_mosi(a_mosi)
    );

    vec_spi_master #(.FRAME_BITS(8), .CLK_DIV(1), .GAP(2)) u_dut_b (
        .i_clk(clk), .i_reset(rst), .i_start(b_start), .i_data(b_data),
        .o_busy(b_busy), .o_done(b_done), .o_vec_csb(b_csb), .o_vec_sclk(b_sclk), .o_vec_mosi(b_mosi)
    );

    // mode-0 slave model for the 90-bit instance
    logic [89:0] a_sh = '0;
    logic [89:0] a_frames[$];
    int          a_lows[$], a_rises[$];
    int          a_low = 0, a_rise = 0, a_rise_cyc = 0, a_fall_cyc = 0, a_gap = 0;
    int          a_done_cnt = 0, a_done_cyc = 0, a_bad_mosi = 0;
    logic        a_psclk = 1'b0, a_pcsb = 1'b1, a_pmosi = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            a_low = 0;
            a_rise = 0;
        end else begin
            if (!a_csb) begin
                a_low++;
                if (a_sclk && !a_psclk) begin
                    a_sh = {a_sh[88:0], a_mosi};
                    a_rise++;
                end
                if (!a_pcsb && a_mosi != a_pmosi && !(a_psclk && !a_sclk)) a_bad_mosi++;
            end
            if (a_csb && !a_pcsb) begin
                a_frames.push_back(a_sh);
                a_lows.push_back(a_low);
                a_rises.push_back(a_rise);
                a_low = 0;
                a_rise = 0;
                a_rise_cyc = cyc;
            end
            if (!a_csb && a_pcsb) begin
                a_fall_cyc = cyc;
                a_gap = cyc - a_rise_cyc;
            end
            if (a_done) begin
                a_done_cnt++;
                a_done_cyc = cyc;
            end
        end
        a_psclk = a_sclk;
        a_pcsb = a_csb;
        a_pmosi = a_mosi;
    end

    // mode-0 slave model for the 8-bit instance, also logging the MOSI bit sequence
    logic [7:0]  b_sh = '0;
    logic [7:0]  b_frames[$];
    logic        b_seq[$];
    int          b_lows[$], b_rises[$];
    int          b_low = 0, b_rise = 0, b_done_cyc = 0, b_bad_mosi = 0;
    logic        b_psclk = 1'b0, b_pcsb = 1'b1, b_pmosi = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            b_low = 0;
            b_rise = 0;
        end else begin
            if (!b_csb) begin
                b_low++;
                if (b_sclk && !b_psclk) begin
                    b_sh = {b_sh[6:0], b_mosi};
                    b_seq.push_back(b_mosi);
                    b_rise++;
                end
                if (!b_pcsb && b_mosi != b_pmosi && !(b_psclk && !b_sclk)) b_bad_mosi++;
            end
            if (b_csb && !b_pcsb) begin
                b_frames.push_back(b_sh);
                b_lows.push_back(b_low);
                b_rises.push_back(b_rise);
                b_low = 0;
                b_rise = 0;
            end
            if (b_done) b_done_cyc = cyc;
        end
        b_psclk = b_sclk;
        b_pcsb = b_csb;
        b_pmosi = b_mosi;
    end

    task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_a(input logic [89:0] d);
        a_start = 1'b1;
        a_data = d;
        t0 = cyc;
        tick();
        a_start = 1'b0;
    endtask

    task automatic wait_frames(input bit sel_b, input int n);
        for (int k = 0; k < 3000 && (sel_b ? b_frames.size() : a_frames.size()) < n; k++) @(posedge clk);
        #1;
        check("frames_seen", sel_b ? b_frames.size() : a_frames.size(), n);
    endtask

    function automatic logic a_sig(input int sel);
        return sel == 0 ? a_busy : sel == 1 ? a_done : a_sclk;
    endfunction

    // returns at a negedge where the selected A output equals val
    task automatic wait_sig(input int sel, input logic val);
        @(negedge clk);
        for (int k = 0; k < 3000 && a_sig(sel) != val; k++) @(negedge clk);
        check("sig_wait", a_sig(sel), val);
    endtask

    localparam logic [89:0] D1 = 90'h2AA_5555_0F0F_F0F0_1234_5678;
    localparam logic [89:0] D2 = 90'h155_AAAA_F0F0_0F0F_EDCB_A987;
    localparam logic [89:0] D3 = 90'h3C3_1111_2222_3333_4444_5555;
    localparam logic [89:0] DA = 90'h0F0_6666_7777_8888_9999_AAAA;
    localparam logic [89:0] DB = 90'h321_BBBB_CCCC_DDDD_EEEE_FFFF;
    localparam logic [89:0] DC = 90'h246_1357_9BDF_0246_8ACE_1001;
    localparam logic [89:0] DD = 90'h3FF_0000_FFFF_0000_FFFF_0001;

    initial begin
        logic [7:0] exp_seq;
        exp_seq = 8'b1010_0101;
        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        check("init_csb", a_csb, 1'b1);
        check("init_sclk", a_sclk, 1'b0);
        check("init_busy", a_busy, 1'b0);
        tick();
        // reset held for 3 cycles in the middle of a frame
        start_a(D1);
        repeat (60) tick();
        check("mid_frame_csb", a_csb, 1'b0);
        rst = 1'b1;
        tick();
        @(negedge clk);
        check("rst_csb", a_csb, 1'b1);
        check("rst_sclk", a_sclk, 1'b0);
        check("rst_mosi", a_mosi, 1'b0);
        check("rst_busy", a_busy, 1'b0);
        check("rst_done", a_done, 1'b0);
        tick();
        tick();
        rst = 1'b0;
        repeat (400) tick();
        check("abort_no_done", a_done_cnt, 0);
        check("abort_no_frame", a_frames.size(), 0);
        // single 90-bit frame
        start_a(D1);
        @(negedge clk);
        check("lat_csb", a_csb, 1'b0);
        check("lat_mosi", a_mosi, 1'b1);
        check("lat_busy", a_busy, 1'b1);
        wait_frames(1'b0, 1);
        check("f1_data", a_frames[0], D1);
        check("f1_csb_low", a_lows[0], 362);
        check("f1_rises", a_rises[0], 90);
        check("f1_done_cyc", a_done_cyc - t0, 363);
        check("f1_fall_cyc", a_fall_cyc - t0, 1);
        // idle restart in the cycle busy falls
        wait_sig(0, 1'b0);
        check("busy_fall", cyc - a_done_cyc, 2);
        a_start = 1'b1;
        a_data = D2;
        @(posedge clk);
        #1;
        a_start = 1'b0;
        @(negedge clk);
        check("idle_restart_csb", a_csb, 1'b0);
        // start pulse during SCLK_HI queues D3 without touching D2
        wait_sig(2, 1'b1);
        a_start = 1'b1;
        a_data = D3;
        @(posedge clk);
        #1;
        a_start = 1'b0;
        wait_frames(1'b0, 2);
        check("f2_data", a_frames[1], D2);
        wait_frames(1'b0, 3);
        check("f3_data", a_frames[2], D3);
        check("f3_gap", a_gap, 2);
        // pending overwrite: B replaced by C
        wait_sig(0, 1'b0);
        tick();
        start_a(DA);
        repeat (20) tick();
        start_a(DB);
        repeat (40) tick();
        start_a(DC);
        wait_frames(1'b0, 5);
        check("ovr_first", a_frames[3], DA);
        check("ovr_second", a_frames[4], DC);
        check("ovr_gap", a_gap, 2);
        wait_sig(0, 1'b0);
        repeat (200) tick();
        check("ovr_b_dropped", a_frames.size(), 5);
        // start coincident with GAP exit: D beats pending B
        start_a(DA);
        repeat (30) tick();
        start_a(DB);
        wait_sig(1, 1'b1);
        @(posedge clk);
        #1;
        a_start = 1'b1;
        a_data = DD;
        tick();
        a_start = 1'b0;
        wait_frames(1'b0, 7);
        check("coin_first", a_frames[5], DA);
        check("coin_second", a_frames[6], DD);
        check("coin_gap", a_gap, 2);
        wait_sig(0, 1'b0);
        repeat (200) tick();
        check("coin_b_dropped", a_frames.size(), 7);
        // 8-bit frame with CLK_DIV=1
        b_start = 1'b1;
        b_data = 8'hA5;
        t0 = cyc;
        tick();
        b_start = 1'b0;
        wait_frames(1'b1, 1);
        check("b_data", b_frames[0], 8'hA5);
        check("b_csb_low", b_lows[0], 17);
        check("b_rises", b_rises[0], 8);
        check("b_done_cyc", b_done_cyc - t0, 18);
        check("b_seq_len", b_seq.size(), 8);
        for (int i = 0; i < 8 && i < b_seq.size(); i++) check($sformatf("b_mosi_%0d", i), b_seq[i], exp_seq[7-i]);
        check("a_mosi_stable", a_bad_mosi, 0);
        check("b_mosi_stable", b_bad_mosi, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
